// File: rtl/frac_div_seq_pkg.sv
// Shared types and constants for the sequential fixed-point divider.
// FRAC_W/FRAC_F here are the default frac_t geometry used by the neuron datapath.
package frac_div_seq_pkg;

    localparam int FRAC_W = 32;
    localparam int FRAC_F = 16;

    typedef logic signed [FRAC_W-1:0] frac_t;

    localparam frac_t FRAC_MAX = 32'h7FFF_FFFF;
    localparam frac_t FRAC_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } frac_div_state_t;

endpackage

// File: rtl/frac_div_step.sv
// One combinational restoring-division step: shift the remainder, try to subtract
// the divisor, keep the difference when it does not go negative.
module frac_div_step
    import frac_div_seq_pkg::*;
#(
    parameter int FRAC_W = frac_div_seq_pkg::FRAC_W
) (
    input  logic [FRAC_W:0]   rem_i,
    input  logic [FRAC_W-1:0] div_i,
    input  logic              shift_in_i,
    output logic [FRAC_W:0]   rem_o,
    output logic              q_bit_o
);

    logic [FRAC_W+1:0] shifted;
    logic [FRAC_W+1:0] trial;

    // One spare top bit makes the borrow of the trial subtraction its sign bit.
    assign shifted = {rem_i, shift_in_i};
    assign trial   = shifted - {2'b00, div_i};
    assign q_bit_o = ~trial[FRAC_W+1];
    assign rem_o   = q_bit_o ? trial[FRAC_W:0] : shifted[FRAC_W:0];

endmodule

// File: rtl/frac_div_seq.sv
// Sequential signed frac_t divider, one restoring bit per clock, valid/ready on both sides.
// Build option: define FRAC_DIV_SATURATE_EN to saturate overflow and divide-by-zero results.
module frac_div_seq #(
    parameter int FRAC_W = frac_div_seq_pkg::FRAC_W,
    parameter int FRAC_F = frac_div_seq_pkg::FRAC_F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FRAC_W-1:0] in_a,
    input  logic [FRAC_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] out_q,
    output logic              out_dbz,
    output logic              out_ovf
);
    import frac_div_seq_pkg::*;

    localparam int NW = FRAC_W + FRAC_F;
    localparam int CW = $clog2(NW + 1);

    localparam logic [NW-1:0]     POS_LIM = {{(FRAC_F + 1){1'b0}}, {(FRAC_W - 1){1'b1}}};
    localparam logic [NW-1:0]     NEG_LIM = POS_LIM + NW'(1);
    localparam logic [FRAC_W-1:0] Q_MAX   = {1'b0, {(FRAC_W - 1){1'b1}}};
    localparam logic [FRAC_W-1:0] Q_MIN   = {1'b1, {(FRAC_W - 1){1'b0}}};

    frac_div_state_t   state_q, state_d;
    logic              neg_q, neg_d;
    logic              dbz_q, dbz_d;
    logic [FRAC_W-1:0] mag_b_q, mag_b_d;
    logic [NW-1:0]     num_q, num_d;
    logic [FRAC_W:0]   rem_q, rem_d;
    logic [NW-1:0]     quo_q, quo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FRAC_W-1:0] out_q_q, out_q_d;
    logic              out_dbz_q, out_dbz_d;
    logic              out_ovf_q, out_ovf_d;
`ifdef FRAC_DIV_SATURATE_EN
    logic              sa_q, sa_d;
`endif

    logic [FRAC_W-1:0] abs_a, abs_b;
    logic [FRAC_W:0]   step_rem;
    logic              step_bit;
    logic [FRAC_W-1:0] quo_low, wrap_q, ovf_fill, dbz_fill;
    logic              ovf_c;

    // Most negative operand maps to 2^(FRAC_W-1), which still fits unsigned.
    assign abs_a = in_a[FRAC_W-1] ? ({FRAC_W{1'b0}} - in_a) : in_a;
    assign abs_b = in_b[FRAC_W-1] ? ({FRAC_W{1'b0}} - in_b) : in_b;

    frac_div_step #(.FRAC_W(FRAC_W)) u_step (
        .rem_i      (rem_q),
        .div_i      (mag_b_q),
        .shift_in_i (num_q[NW-1]),
        .rem_o      (step_rem),
        .q_bit_o    (step_bit)
    );

    assign quo_low = quo_q[FRAC_W-1:0];
    assign wrap_q  = neg_q ? ({FRAC_W{1'b0}} - quo_low) : quo_low;
    assign ovf_c   = neg_q ? (quo_q > NEG_LIM) : (quo_q > POS_LIM);

`ifdef FRAC_DIV_SATURATE_EN
    assign ovf_fill = neg_q ? Q_MIN : Q_MAX;
    assign dbz_fill = sa_q ? Q_MIN : Q_MAX;
`else
    assign ovf_fill = wrap_q;
    assign dbz_fill = '0;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_q     = out_q_q;
    assign out_dbz   = out_dbz_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        // NOTE: every target gets a default first, so no path through the case leaves a latch.
        state_d   = state_q;
        neg_d     = neg_q;
        dbz_d     = dbz_q;
        mag_b_d   = mag_b_q;
        num_d     = num_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        out_q_d   = out_q_q;
        out_dbz_d = out_dbz_q;
        out_ovf_d = out_ovf_q;
`ifdef FRAC_DIV_SATURATE_EN
        sa_d      = sa_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef FRAC_DIV_SATURATE_EN
                    sa_d    = in_a[FRAC_W-1];
`endif
                    neg_d   = in_a[FRAC_W-1] ^ in_b[FRAC_W-1];
                    mag_b_d = abs_b;
                    rem_d   = '0;
                    quo_d   = '0;
                    if (in_b == '0) begin
                        // Zero divisor skips RUN; one spare FIX cycle gives a fixed two-edge latency.
                        dbz_d   = 1'b1;
                        num_d   = '0;
                        cnt_d   = CW'(1);
                        state_d = ST_FIX;
                    end else begin
                        dbz_d   = 1'b0;
                        num_d   = {abs_a, {FRAC_F{1'b0}}};
                        cnt_d   = CW'(NW);
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                rem_d = step_rem;
                quo_d = {quo_q[NW-2:0], step_bit};
                num_d = {num_q[NW-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ST_DONE;
                    if (dbz_q) begin
                        out_q_d   = dbz_fill;
                        out_dbz_d = 1'b1;
                        out_ovf_d = 1'b0;
                    end else begin
                        out_q_d   = ovf_c ? ovf_fill : wrap_q;
                        out_dbz_d = 1'b0;
                        out_ovf_d = ovf_c;
                    end
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            neg_q     <= 1'b0;
            dbz_q     <= 1'b0;
            mag_b_q   <= '0;
            num_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            out_q_q   <= '0;
            out_dbz_q <= 1'b0;
            out_ovf_q <= 1'b0;
`ifdef FRAC_DIV_SATURATE_EN
            sa_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge value of its peers.
            state_q   <= state_d;
            neg_q     <= neg_d;
            dbz_q     <= dbz_d;
            mag_b_q   <= mag_b_d;
            num_q     <= num_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            out_q_q   <= out_q_d;
            out_dbz_q <= out_dbz_d;
            out_ovf_q <= out_ovf_d;
`ifdef FRAC_DIV_SATURATE_EN
            sa_q      <= sa_d;
`endif
        end
    end

endmodule

// File: tb/tb_frac_div_seq.sv
// Self-checking bench for frac_div_seq: directed vector table, corner sequences,
// and random operands against a signed-integer-division reference.
module tb_frac_div_seq;

    localparam int W = 32;
    localparam int F = 16;
    localparam logic [31:0] QMAXV = 32'h7FFF_FFFF;
    localparam logic [31:0] QMINV = 32'h8000_0000;
    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
    logic        out_dbz;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frac_div_seq #(.FRAC_W(W), .FRAC_F(F)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_dbz   (out_dbz),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: true quotient a*2^F/b as a signed integer, truncated toward zero.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic dbz, output logic ovf);
        longint sa, sb, qt;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            dbz = 1'b1;
            ovf = 1'b0;
`ifdef FRAC_DIV_SATURATE_EN
            q = (sa < 0) ? QMINV : QMAXV;
`else
            q = 32'h0;
`endif
        end else begin
            dbz = 1'b0;
            qt  = (sa * 65536) / sb;
            ovf = (qt > LMAX) || (qt < LMIN);
            q   = qt[31:0];
`ifdef FRAC_DIV_SATURATE_EN
            if (ovf) q = (qt < 0) ? QMINV : QMAXV;
`endif
        end
    endfunction

    task automatic wait_idle();
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic dbz, output logic ovf, output int lat);
        wait_idle();
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat);
        q   = out_q;
        dbz = out_dbz;
        ovf = out_ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[10];
        logic [31:0] q, eq, a, b;
        logic        dbz, ovf, edbz, eovf;
        int          lat, mode;

        vt[0] = '{"exact_6_2",     32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0, 49};
        vt[1] = '{"trunc_1_3",     32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 49};
        vt[2] = '{"neg_7p5_2p5",   32'hFFF8_8000, 32'h0002_8000, 32'hFFFD_0000, 1'b0, 1'b0, 49};
        vt[3] = '{"min_by_one",    32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 49};
        vt[4] = '{"zero_by_neg",   32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b0, 1'b0, 49};
`ifdef FRAC_DIV_SATURATE_EN
        vt[5] = '{"dbz_pos",       32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
        vt[6] = '{"dbz_neg",       32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
        vt[7] = '{"ovf_pos",       32'h7530_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 49};
        vt[8] = '{"ovf_neg",       32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 49};
        vt[9] = '{"ovf_min_by_m1", 32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 49};
`else
        vt[5] = '{"dbz_pos",       32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 2};
        vt[6] = '{"dbz_neg",       32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 2};
        vt[7] = '{"ovf_pos",       32'h7530_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 49};
        vt[8] = '{"ovf_neg",       32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 49};
        vt[9] = '{"ovf_min_by_m1", 32'h8000_0000, 32'hFFFF_0000, 32'h8000_0000, 1'b0, 1'b1, 49};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_q",     {32'd0, out_q},     64'd0);
        check("rst_out_dbz",   {63'd0, out_dbz},   64'd0);
        check("rst_out_ovf",   {63'd0, out_ovf},   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_op(vt[i].a, vt[i].b, q, dbz, ovf, lat);
            check({vt[i].name, "_q"},   {32'd0, q},   {32'd0, vt[i].q});
            check({vt[i].name, "_dbz"}, {63'd0, dbz}, {63'd0, vt[i].dbz});
            check({vt[i].name, "_ovf"}, {63'd0, ovf}, {63'd0, vt[i].ovf});
            check({vt[i].name, "_lat"}, 64'(lat),     64'(vt[i].lat));
        end

        // Back-pressure: result held for 10 cycles while new operands are offered.
        wait_idle();
        in_a = 32'h0006_0000;
        in_b = 32'h0002_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 32'h0001_0000;
        in_b = 32'h0003_0000;
        wait_result(lat);
        check("bp_lat", 64'(lat), 64'd49);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_q_stable", {32'd0, out_q},     64'h0003_0000);
            check("bp_in_ready", {63'd0, in_ready},  64'd0);
            check("bp_valid",    {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_take_idle",  {63'd0, in_ready},  64'd1);
        check("bp_take_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_accept", {63'd0, in_ready}, 64'd0);
        wait_result(lat);
        check("bp_next_lat", 64'(lat), 64'd49);
        check("bp_next_q", {32'd0, out_q}, 64'h0000_5555);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset 20 cycles into RUN discards the operation.
        wait_idle();
        in_a = 32'h0001_0000;
        in_b = 32'h0003_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready},  64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(32'h0006_0000, 32'h0002_0000, q, dbz, ovf, lat);
        check("post_rst_q",   {32'd0, q}, 64'h0003_0000);
        check("post_rst_lat", 64'(lat),   64'd49);

        // Random operands against the reference.
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 3));
            a = $urandom();
            b = $urandom();
            if (mode == 1) begin
                b = $urandom_range(1, 32'h3FF);
                if ($urandom_range(0, 1) == 1) b = -b;
            end else if (mode == 2) begin
                b = (i % 2 == 0) ? 32'h0 : 32'h0001_0000;
            end else if (mode == 3) begin
                a = $urandom_range(0, 32'h000F_FFFF);
                if ($urandom_range(0, 1) == 1) a = -a;
            end
            model(a, b, eq, edbz, eovf);
            do_op(a, b, q, dbz, ovf, lat);
            check("rnd_q",   {32'd0, q},   {32'd0, eq});
            check("rnd_dbz", {63'd0, dbz}, {63'd0, edbz});
            check("rnd_ovf", {63'd0, ovf}, {63'd0, eovf});
            check("rnd_lat", 64'(lat),     (b == 32'h0) ? 64'd2 : 64'd49);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
